// File: rtl/dcf77_decoder_pkg.sv
// Shared types and constants for the DCF77 frame decoder: field layout of the
// 59-bit minute frame, the decoded time-of-day struct and a BCD minute increment.
package dcf77_decoder_pkg;

  typedef logic [7:0] bcd_t;

  typedef struct packed {
    bcd_t       year;
    bcd_t       month;
    bcd_t       day;
    logic [2:0] dow;
    bcd_t       hour;
    bcd_t       minute;
  } dcf77_time_t;

  localparam logic [5:0] START_POS      = 6'd0;
  localparam logic [5:0] BEGIN_TIME_POS = 6'd20;
  localparam logic [5:0] MINUTE_POS     = 6'd21;
  localparam logic [5:0] P1_POS         = 6'd28;
  localparam logic [5:0] HOUR_POS       = 6'd29;
  localparam logic [5:0] P2_POS         = 6'd35;
  localparam logic [5:0] DAY_POS        = 6'd36;
  localparam logic [5:0] DOW_POS        = 6'd42;
  localparam logic [5:0] MONTH_POS      = 6'd45;
  localparam logic [5:0] YEAR_POS       = 6'd50;
  localparam logic [5:0] P3_POS         = 6'd58;

  // Next BCD minute, 59 wraps to 00.
  function automatic bcd_t bcd_inc59(input bcd_t m);
    if (m == 8'h59) return 8'h00;
    if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    return m + 8'd1;
  endfunction

endpackage

// File: rtl/dcf77_range_check.sv
// Combinational BCD range check of a decoded DCF77 time: every nibble a digit
// and each field inside its calendar/clock range.
module dcf77_range_check
  import dcf77_decoder_pkg::*;
(
  input  dcf77_time_t tod,
  output logic        range_ok
);

  function automatic logic digits_ok(input bcd_t v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  assign range_ok = digits_ok(tod.year) && digits_ok(tod.month) &&
                    digits_ok(tod.day) && digits_ok(tod.hour) &&
                    digits_ok(tod.minute) &&
                    (tod.minute <= 8'h59) && (tod.hour <= 8'h23) &&
                    (tod.day != 8'h00) && (tod.day <= 8'h31) &&
                    (tod.month != 8'h00) && (tod.month <= 8'h12) &&
                    (tod.dow != 3'd0);

endmodule

// File: rtl/dcf77_decoder.sv
// Validates DCF77 minute frames (framing, parity, range, continuity) and issues a
// time set with a one-cycle time_valid once locked. DCF77_DECODER_STATS_EN adds error counters.
module dcf77_decoder
  import dcf77_decoder_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [58:0] data_hold,
  input  logic        sync,
  output logic [7:0]  year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [2:0]  day_of_week,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic        time_valid,
  output logic        locked,
  output logic        err_parity,
  output logic        err_range,
  output logic        busy
`ifdef DCF77_DECODER_STATS_EN
  ,
  output logic [7:0]  parity_err_cnt,
  output logic [7:0]  range_err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, CHECK, UPDATE} state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);

  state_t      state, state_next;
  logic [58:0] frame;
  logic [5:0]  idx;
  logic        acc, acc_next, bit_now, par_hit;
  logic        par_fail, rng_fail, plaus, plausible, range_ok;
  logic [2:0]  count, cnt_new;
  dcf77_time_t cur, prev;

  always_comb begin
    cur        = '0;
    cur.minute = {1'b0, frame[MINUTE_POS +: 7]};
    cur.hour   = {2'b0, frame[HOUR_POS +: 6]};
    cur.day    = {2'b0, frame[DAY_POS +: 6]};
    cur.dow    = frame[DOW_POS +: 3];
    cur.month  = {3'b0, frame[MONTH_POS +: 5]};
    cur.year   = frame[YEAR_POS +: 8];
  end

  dcf77_range_check u_range_check (
    .tod      (cur),
    .range_ok (range_ok)
  );

  // Continuity: minute steps by one; other fields only compared when the hour did not roll.
  assign plausible = (cur.minute == bcd_inc59(prev.minute)) &&
                     ((cur.minute == 8'h00) ||
                      ((cur.hour == prev.hour) && (cur.day == prev.day) &&
                       (cur.dow == prev.dow) && (cur.month == prev.month) &&
                       (cur.year == prev.year)));

  // Parity groups restart at the first bit of minute, hour and date fields.
  always_comb begin
    bit_now  = frame[idx];
    acc_next = ((idx == MINUTE_POS) || (idx == HOUR_POS) || (idx == DAY_POS)) ?
               bit_now : (acc ^ bit_now);
    par_hit  = (((idx == P1_POS) || (idx == P2_POS) || (idx == P3_POS)) && acc_next) ||
               ((idx == START_POS) && bit_now) ||
               ((idx == BEGIN_TIME_POS) && !bit_now);
  end

  assign cnt_new = !plaus ? 3'd1 : ((count >= LOCK_CNT) ? LOCK_CNT : count + 3'd1);
  assign locked  = (count == LOCK_CNT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sync) state_next = SCAN;
      SCAN:    if (idx == P3_POS) state_next = CHECK;
      CHECK:   state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame       <= '0;
      idx         <= '0;
      acc         <= 1'b0;
      par_fail    <= 1'b0;
      rng_fail    <= 1'b0;
      plaus       <= 1'b0;
      count       <= '0;
      prev        <= '0;
      year        <= '0;
      month       <= '0;
      day         <= '0;
      day_of_week <= '0;
      hour        <= '0;
      minute      <= '0;
      time_valid  <= 1'b0;
      err_parity  <= 1'b0;
      err_range   <= 1'b0;
`ifdef DCF77_DECODER_STATS_EN
      parity_err_cnt <= '0;
      range_err_cnt  <= '0;
`endif
    end else begin
      time_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            frame    <= data_hold;
            idx      <= '0;
            acc      <= 1'b0;
            par_fail <= 1'b0;
          end
        end
        SCAN: begin
          acc <= acc_next;
          idx <= idx + 6'd1;
          if (par_hit) par_fail <= 1'b1;
        end
        CHECK: begin
          rng_fail <= !range_ok;
          plaus    <= plausible;
        end
        UPDATE: begin
          err_parity <= par_fail;
          err_range  <= rng_fail;
`ifdef DCF77_DECODER_STATS_EN
          if (par_fail && (parity_err_cnt != 8'hff)) parity_err_cnt <= parity_err_cnt + 8'd1;
          if (rng_fail && (range_err_cnt != 8'hff))  range_err_cnt  <= range_err_cnt + 8'd1;
`endif
          if (par_fail || rng_fail) begin
            count <= '0;
          end else begin
            count <= cnt_new;
            prev  <= cur;
            if (cnt_new == LOCK_CNT) begin
              year        <= cur.year;
              month       <= cur.month;
              day         <= cur.day;
              day_of_week <= cur.dow;
              hour        <= cur.hour;
              minute      <= cur.minute;
              time_valid  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcf77_decoder.sv
// Directed bench for dcf77_decoder: a table of minute frames with expected lock,
// error and time outputs, plus sequences for sync-while-busy and reset mid-scan.
module tb_dcf77_decoder;

  logic        clk;
  logic        rst;
  logic [58:0] data_hold;
  logic        sync;
  logic [7:0]  year, month, day, hour, minute;
  logic [2:0]  day_of_week;
  logic        time_valid, locked, err_parity, err_range, busy;
`ifdef DCF77_DECODER_STATS_EN
  logic [7:0]  parity_err_cnt, range_err_cnt;
`endif

  dcf77_decoder #(.LOCK_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_hold   (data_hold),
    .sync        (sync),
    .year        (year),
    .month       (month),
    .day         (day),
    .day_of_week (day_of_week),
    .hour        (hour),
    .minute      (minute),
    .time_valid  (time_valid),
    .locked      (locked),
    .err_parity  (err_parity),
    .err_range   (err_range),
    .busy        (busy)
`ifdef DCF77_DECODER_STATS_EN
    ,
    .parity_err_cnt (parity_err_cnt),
    .range_err_cnt  (range_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [58:0] frame;
    logic        exp_valid;
    logic        exp_locked;
    logic        exp_perr;
    logic        exp_rerr;
    logic [42:0] exp_time;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  // Frame with correct framing and even parity over minute, hour and date groups.
  function automatic logic [58:0] mk(input logic [7:0] y, input logic [4:0] mo, input logic [5:0] d,
                                     input logic [2:0] w, input logic [5:0] h, input logic [6:0] mi);
    logic [58:0] f;
    f        = '0;
    f[20]    = 1'b1;
    f[27:21] = mi;
    f[28]    = ^mi;
    f[34:29] = h;
    f[35]    = ^h;
    f[41:36] = d;
    f[44:42] = w;
    f[49:45] = mo;
    f[57:50] = y;
    f[58]    = ^f[57:36];
    return f;
  endfunction

  function automatic logic [42:0] tp(input logic [7:0] y, input logic [4:0] mo, input logic [5:0] d,
                                     input logic [2:0] w, input logic [5:0] h, input logic [6:0] mi);
    return {y, 3'b0, mo, 2'b0, d, w, 2'b0, h, 1'b0, mi};
  endfunction

  function automatic logic [58:0] fr(input logic [5:0] h, input logic [6:0] mi);
    return mk(8'h24, 5'h03, 6'h15, 3'd5, h, mi);
  endfunction

  function automatic logic [42:0] tt(input logic [5:0] h, input logic [6:0] mi);
    return tp(8'h24, 5'h03, 6'h15, 3'd5, h, mi);
  endfunction

  function automatic logic [63:0] outs();
    return 64'({year, month, day, day_of_week, hour, minute});
  endfunction

  task automatic set_v(input int i, input logic [58:0] f, input logic v, input logic l,
                       input logic pe, input logic re, input logic [42:0] t);
    vecs[i].frame      = f;
    vecs[i].exp_valid  = v;
    vecs[i].exp_locked = l;
    vecs[i].exp_perr   = pe;
    vecs[i].exp_rerr   = re;
    vecs[i].exp_time   = t;
  endtask

  // Sync one frame and watch 70 cycles; optional second sync and reset at given cycles.
  task automatic apply_frame(input logic [58:0] f, input int alt_k, input logic [58:0] alt_f,
                             input int rst_k, output int pulses, output int first_k, output int busy_cnt);
    logic [63:0] r;
    @(negedge clk);
    data_hold = f;
    sync      = 1'b1;
    pulses    = 0;
    first_k   = 0;
    busy_cnt  = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (time_valid) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (busy) busy_cnt++;
      sync = 1'b0;
      if (k == 5) begin
        r = {$urandom(), $urandom()};
        data_hold = r[58:0];
      end
      if (k == alt_k) begin
        data_hold = alt_f;
        sync      = 1'b1;
      end
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 2) rst = 1'b0;
    end
  endtask

  logic [58:0] p2_bad;

  initial begin
    int pulses, first_k, busy_cnt;

    set_v(0,  fr(6'h13, 7'h45),                       0, 0, 0, 0, 43'd0);
    set_v(1,  fr(6'h13, 7'h46),                       1, 1, 0, 0, tt(6'h13, 7'h46));
    set_v(2,  fr(6'h13, 7'h47) ^ (59'd1 << 30),       0, 0, 1, 0, tt(6'h13, 7'h46));
    set_v(3,  fr(6'h13, 7'h48),                       0, 0, 0, 0, tt(6'h13, 7'h46));
    set_v(4,  fr(6'h13, 7'h49),                       1, 1, 0, 0, tt(6'h13, 7'h49));
    set_v(5,  mk(8'h24, 5'h13, 6'h15, 3'd5, 6'h13, 7'h50), 0, 0, 0, 1, tt(6'h13, 7'h49));
    set_v(6,  fr(6'h13, 7'h59),                       0, 0, 0, 0, tt(6'h13, 7'h49));
    set_v(7,  fr(6'h14, 7'h00),                       1, 1, 0, 0, tt(6'h14, 7'h00));
    set_v(8,  fr(6'h13, 7'h45),                       0, 0, 0, 0, tt(6'h14, 7'h00));
    set_v(9,  fr(6'h13, 7'h47),                       0, 0, 0, 0, tt(6'h14, 7'h00));
    set_v(10, fr(6'h13, 7'h48),                       1, 1, 0, 0, tt(6'h13, 7'h48));
    set_v(11, fr(6'h24, 7'h49),                       0, 0, 0, 1, tt(6'h13, 7'h48));
    set_v(12, fr(6'h13, 7'h49) & ~(59'd1 << 20),      0, 0, 1, 0, tt(6'h13, 7'h48));
    set_v(13, fr(6'h13, 7'h49) | 59'd1,               0, 0, 1, 0, tt(6'h13, 7'h48));
    set_v(14, fr(6'h13, 7'h49),                       0, 0, 0, 0, tt(6'h13, 7'h48));
    set_v(15, fr(6'h13, 7'h50),                       1, 1, 0, 0, tt(6'h13, 7'h50));
    set_v(16, mk(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h51), 0, 0, 0, 0, tt(6'h13, 7'h50));
    set_v(17, mk(8'h24, 5'h03, 6'h16, 3'd0, 6'h13, 7'h52), 0, 0, 0, 1, tt(6'h13, 7'h50));
    set_v(18, mk(8'h24, 5'h03, 6'h32, 3'd5, 6'h13, 7'h52), 0, 0, 0, 1, tt(6'h13, 7'h50));
    set_v(19, fr(6'h13, 7'h1A),                       0, 0, 0, 1, tt(6'h13, 7'h50));
    set_v(20, mk(8'h24, 5'h13, 6'h15, 3'd5, 6'h13, 7'h52) ^ (59'd1 << 30), 0, 0, 1, 1, tt(6'h13, 7'h50));
    set_v(21, mk(8'h24, 5'h03, 6'h00, 3'd5, 6'h13, 7'h52), 0, 0, 0, 1, tt(6'h13, 7'h50));

    rst       = 1'b1;
    sync      = 1'b0;
    data_hold = '0;
    repeat (3) @(negedge clk);
    check("reset_time", -1, outs(), 64'd0);
    check("reset_flags", -1, 64'({time_valid, locked, err_parity, err_range, busy}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_flags", -1, 64'({time_valid, locked, err_parity, err_range, busy}), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply_frame(vecs[i].frame, 0, '0, 0, pulses, first_k, busy_cnt);
      check("valid_pulses", i, 64'(pulses), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check("valid_latency", i, 64'(first_k), 64'd62);
      check("busy_cycles", i, 64'(busy_cnt), 64'd61);
      check("locked", i, 64'(locked), 64'(vecs[i].exp_locked));
      check("err_parity", i, 64'(err_parity), 64'(vecs[i].exp_perr));
      check("err_range", i, 64'(err_range), 64'(vecs[i].exp_rerr));
      check("time", i, outs(), 64'(vecs[i].exp_time));
    end

    // Second sync ten cycles into the scan must be ignored.
    apply_frame(mk(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h52), 10, fr(6'h13, 7'h10), 0,
                pulses, first_k, busy_cnt);
    check("busy_sync_pulses", 100, 64'(pulses), 64'd0);
    check("busy_sync_busy", 100, 64'(busy_cnt), 64'd61);
    check("busy_sync_locked", 100, 64'(locked), 64'd0);
    apply_frame(mk(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h53), 0, '0, 0, pulses, first_k, busy_cnt);
    check("relock_pulses", 101, 64'(pulses), 64'd1);
    check("relock_latency", 101, 64'(first_k), 64'd62);
    check("relock_time", 101, outs(), 64'(tp(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h53)));
    check("relock_locked", 101, 64'(locked), 64'd1);

    // Reset in the middle of a frame that would otherwise validate.
    apply_frame(mk(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h54), 0, '0, 31, pulses, first_k, busy_cnt);
    check("rst_pulses", 102, 64'(pulses), 64'd0);
    check("rst_busy", 102, 64'(busy_cnt), 64'd31);
    check("rst_time", 102, outs(), 64'd0);
    check("rst_flags", 102, 64'({locked, err_parity, err_range, busy}), 64'd0);
    apply_frame(mk(8'h24, 5'h03, 6'h16, 3'd5, 6'h13, 7'h55), 0, '0, 0, pulses, first_k, busy_cnt);
    check("post_rst_pulses", 103, 64'(pulses), 64'd0);
    check("post_rst_locked", 103, 64'(locked), 64'd0);
    check("post_rst_time", 103, outs(), 64'd0);

`ifdef DCF77_DECODER_STATS_EN
    check("stats_parity_start", 104, 64'(parity_err_cnt), 64'd0);
    p2_bad = fr(6'h13, 7'h45) ^ (59'd1 << 30);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      data_hold = p2_bad;
      sync      = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      repeat (62) @(negedge clk);
    end
    check("stats_parity_sat", 105, 64'(parity_err_cnt), 64'd255);
    check("stats_range_zero", 105, 64'(range_err_cnt), 64'd0);
`else
    p2_bad = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcf77_decoder.md
Name: dcf77_decoder

Overview:
- Sits between the DCF77 bit receiver (`dcf77`) and the time-of-day counter (`clock`).
- Takes the captured 59-bit minute frame and the receiver's frame pulse.
- Checks framing bits, even parity P1/P2/P3 and BCD field ranges, then checks the frame against the previous good one.
- Issues a validated time set plus a one-cycle `time_valid` pulse only when locked; `time_valid` replaces the raw receiver sync at `clock.dcf77_sync`.

Parameters:
- LOCK_FRAMES, 2, consecutive good and plausible frames required before lock (legal 1..7).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- data_hold  input  59  frame from receiver; bit n = second n
- sync  input  1  one-cycle pulse: data_hold holds a new complete frame
- year  output  8  BCD 00-99
- month  output  8  BCD 01-12
- day  output  8  BCD 01-31
- day_of_week  output  3  1=Mon..7=Sun
- hour  output  8  BCD 00-23
- minute  output  8  BCD 00-59
- time_valid  output  1  one-cycle pulse: outputs updated with a validated time
- locked  output  1  level: consecutive-good count == LOCK_FRAMES
- err_parity  output  1  last evaluated frame failed framing or parity
- err_range  output  1  last evaluated frame failed range check
- busy  output  1  frame evaluation in progress

Behaviour:
- Reset (async): all time outputs 0, all flags 0, FSM IDLE, good-frame count 0, previous-frame register 0.
- FSM states: IDLE, SCAN, CHECK, UPDATE.
- IDLE:
  - On sync=1, capture data_hold into frame register, idx<=0, parity accumulator <=0, go to SCAN.
  - busy=1 from the next cycle until return to IDLE.
- SCAN: one bit per cycle, idx 0..58 (59 cycles).
  - Accumulator XORs frame[idx] and is cleared at idx 21, 29 and 36 before the XOR.
  - At idx 28, 35 and 58, after the XOR, a nonzero accumulator sets the internal parity-fail flag (P1, P2, P3 respectively).
  - Framing checked at idx 0 (must be 0) and idx 20 (must be 1); violation sets the same flag.
  - After idx 58, go to CHECK.
- CHECK (1 cycle):
  - Range rules:
    - Every BCD nibble ≤ 9.
    - minute ≤ 59; hour ≤ 23.
    - day 01-31; month 01-12; dow 1-7.
  - Plausible when minute == prev_minute+1 in BCD, with 59 wrapping to 00.
  - When no wrap, hour, day, dow, month and year must also equal the previous frame; on wrap to 00 only the minute is compared.
- UPDATE (1 cycle), then IDLE:
  - err_parity and err_range are registered for this frame.
  - Bad frame (either error): count<=0, locked<=0, previous frame unchanged.
  - Good frame:
    - count <= plausible ? min(count+1, LOCK_FRAMES) : 1.
    - Previous frame <= this frame.
  - If the new count == LOCK_FRAMES: load the time outputs and pulse time_valid.
- Latency: sync in cycle T gives the time_valid pulse in cycle T+62 (registered outputs visible in the same cycle).
- sync while busy is ignored; the in-flight frame completes unaffected.
- data_hold changing during SCAN has no effect (frame is captured).
- Outputs hold their last validated value across bad frames and loss of lock.
- Reset mid-SCAN: immediate return to reset state; no time_valid pulse.

Optional Feature:
- Macro: DCF77_DECODER_STATS_EN.
- Defined:
  - Adds outputs parity_err_cnt[7:0] and range_err_cnt[7:0].
  - Each counter saturates at 255 and increments in UPDATE for its error type.
  - A frame failing both increments both counters.
  - Both counters cleared only by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared types package gains:
  - dcf77_time_t struct (year, month, day, dow, hour, minute).
  - Bit-position constants for each field and for P1=28, P2=35, P3=58, START=0, BEGIN_TIME=20.
  - A bcd_inc59 function.
- Existing bcd_t is reused.
- One combinational sub-module, dcf77_range_check: dcf77_time_t in, range_ok out.

Test Plan:
- Valid frame 2024-03-15 Fri 13:45 (correct parity), then 13:46 sent 60000 cycles later, LOCK_FRAMES=2 -> no time_valid after the first frame; after the second, time_valid 62 cycles after sync, outputs 24/03/15/5/13/46, locked=1.
- Locked, then a frame with bit 30 flipped (P2 wrong) -> err_parity=1, locked=0, no time_valid, outputs still 13:46; next two good frames (13:48, 13:49) relock with outputs 13:49.
- Frame with month=8'h13 and correct parity -> err_range=1, err_parity=0, count cleared.
- Consecutive frames 13:59 then 14:00 -> plausible via minute wrap; locked with outputs 14:00. Frames 13:45 then 13:47 -> count=1, not locked.
- Second sync pulse 10 cycles after the first -> ignored, single evaluation, busy high for 61 cycles; rst asserted at cycle 30 of SCAN -> all outputs 0, no time_valid pulse.
- With DCF77_DECODER_STATS_EN: 300 parity-bad frames -> parity_err_cnt=255, range_err_cnt=0.
